// File: rtl/path_count_scheduler.sv
// Depth-first path counter: walks a DAG through the adjacency_map query/reply port
// and counts every distinct path from start_node to end_node using an on-chip LIFO.
// Latency: POP, CHECK, QUERY, map setup, then one cycle per child beat for each expanded node.
// Backpressure: query_valid waits for query_ready. reply_ready is high for the whole reply burst.
// Ports: clk/reset; start with start_node/end_node; query_valid/query_ready/query_data to the map;
//        reply_valid/reply_ready/reply_data/reply_last from the map; busy/done/overflow/path_count status.
module path_count_scheduler #(
  parameter int NODE_WIDTH  = 10,
  parameter int STACK_DEPTH = 256,
  parameter int COUNT_WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NODE_WIDTH-1:0]  start_node,
  input  logic [NODE_WIDTH-1:0]  end_node,
  input  logic                   query_ready,
  output logic                   query_valid,
  output logic [NODE_WIDTH-1:0]  query_data,
  input  logic                   reply_valid,
  input  logic [NODE_WIDTH-1:0]  reply_data,
  input  logic                   reply_last,
  output logic                   reply_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] path_count
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam int AW   = SP_W - 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_CHECK,
    S_QUERY,
    S_RECV,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [NODE_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]       sp;
  logic [SP_W-1:0]       sp_m1;
  logic [NODE_WIDTH-1:0] node_q;
  logic [NODE_WIDTH-1:0] target_q;
  logic                  stack_full;

  // Control strobes decoded by the FSM, applied by the datapath below.
  logic do_start, do_pop, do_hit, do_qload, do_push, do_drop;

  assign sp_m1      = sp - SP_W'(1);
  assign stack_full = (sp == SP_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    query_valid = 1'b0;
    reply_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    do_start    = 1'b0;
    do_pop      = 1'b0;
    do_hit      = 1'b0;
    do_qload    = 1'b0;
    do_push     = 1'b0;
    do_drop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          do_start = 1'b1;
          state_nx = S_POP;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          do_start = 1'b1;
          state_nx = S_POP;
        end
      end
      S_POP: begin
        busy = 1'b1;
        if (sp == '0) begin
          state_nx = S_DONE;
        end else begin
          do_pop   = 1'b1;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        // The target is counted, never expanded.
        if (node_q == target_q) begin
          do_hit   = 1'b1;
          state_nx = S_POP;
        end else begin
          do_qload = 1'b1;
          state_nx = S_QUERY;
        end
      end
      S_QUERY: begin
        busy        = 1'b1;
        // The map latches on query_valid alone, so it must never rise without ready.
        query_valid = query_ready;
        if (query_ready) state_nx = S_RECV;
      end
      S_RECV: begin
        busy        = 1'b1;
        reply_ready = 1'b1;
        if (reply_valid) begin
          if (stack_full) do_drop = 1'b1;
          else            do_push = 1'b1;
          // After any dropped child the count is meaningless, so stop once the burst ends.
          if (reply_last) state_nx = (overflow || stack_full) ? S_DONE : S_POP;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp         <= '0;
      target_q   <= '0;
      query_data <= '0;
      overflow   <= 1'b0;
      path_count <= '0;
    end else begin
      if (do_start) begin
        target_q   <= end_node;
        sp         <= SP_W'(1);
        overflow   <= 1'b0;
        path_count <= '0;
      end
      if (do_pop)   sp         <= sp_m1;
      if (do_push)  sp         <= sp + SP_W'(1);
      if (do_hit)   path_count <= path_count + COUNT_WIDTH'(1);
      if (do_qload) query_data <= node_q;
      if (do_drop)  overflow   <= 1'b1;
    end
  end

  // Stack storage and registered pop read; contents need no reset since sp gates validity.
  always_ff @(posedge clk) begin
    if (do_start)     stack_mem[0]          <= start_node;
    else if (do_push) stack_mem[sp[AW-1:0]] <= reply_data;
    if (do_pop)       node_q                <= stack_mem[sp_m1[AW-1:0]];
  end

endmodule

// File: tb/tb_path_count_scheduler.sv
module tb_path_count_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: default depth, driven by a table-based adjacency model.
  logic        start_a;
  logic [9:0]  sn_a, en_a;
  logic        qr_a, qv_a, rv_a, rl_a, rr_a, busy_a, done_a, ovf_a;
  logic [9:0]  qd_a, rd_a;
  logic [47:0] pc_a;

  // Instance B: two-entry stack for the overflow case.
  logic        start_b;
  logic [9:0]  sn_b, en_b;
  logic        qr_b, qv_b, rv_b, rl_b, rr_b, busy_b, done_b, ovf_b;
  logic [9:0]  qd_b, rd_b;
  logic [47:0] pc_b;

  path_count_scheduler dut_a (
    .clk(clk), .reset(reset), .start(start_a), .start_node(sn_a), .end_node(en_a),
    .query_ready(qr_a), .query_valid(qv_a), .query_data(qd_a),
    .reply_valid(rv_a), .reply_data(rd_a), .reply_last(rl_a), .reply_ready(rr_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .path_count(pc_a)
  );

  path_count_scheduler #(.NODE_WIDTH(10), .STACK_DEPTH(2), .COUNT_WIDTH(48)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .start_node(sn_b), .end_node(en_b),
    .query_ready(qr_b), .query_valid(qv_b), .query_data(qd_b),
    .reply_valid(rv_b), .reply_data(rd_b), .reply_last(rl_b), .reply_ready(rr_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .path_count(pc_b)
  );

  // Adjacency model A: one setup cycle after a query, then one child per accepted beat.
  logic [9:0] adj [0:7][0:3];
  int         nch [0:7];
  logic [9:0] m_node;
  int         m_idx;
  int         m_ph;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= 0; m_idx <= 0; m_node <= '0;
      rv_a <= 1'b0; rd_a <= '0; rl_a <= 1'b0;
    end else begin
      case (m_ph)
        0: if (qv_a) begin m_node <= qd_a; m_ph <= 1; end
        1: begin
          rv_a  <= 1'b1;
          rd_a  <= adj[m_node[2:0]][0];
          rl_a  <= (nch[m_node[2:0]] == 1);
          m_idx <= 0;
          m_ph  <= 2;
        end
        default: if (rv_a && rr_a) begin
          if (rl_a) begin
            rv_a <= 1'b0; m_ph <= 0;
          end else begin
            rd_a  <= adj[m_node[2:0]][m_idx+1];
            rl_a  <= (m_idx + 2 == nch[m_node[2:0]]);
            m_idx <= m_idx + 1;
          end
        end
      endcase
    end
  end

  // Adjacency model B: any query returns children 1, 2, 3.
  int ph_b, beats_b;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_b <= 0; beats_b <= 0; rv_b <= 1'b0; rd_b <= '0; rl_b <= 1'b0;
    end else begin
      case (ph_b)
        0: if (qv_b) ph_b <= 1;
        1: begin rv_b <= 1'b1; rd_b <= 10'd1; rl_b <= 1'b0; ph_b <= 2; end
        default: if (rv_b && rr_b) begin
          beats_b <= beats_b + 1;
          if (rl_b) begin
            rv_b <= 1'b0; ph_b <= 0;
          end else begin
            rd_b <= rd_b + 10'd1;
            rl_b <= (rd_b == 10'd2);
          end
        end
      endcase
    end
  end

  // Observers sampled on the falling edge.
  int   qpulses = 0, curw = 0, maxw = 0, qv_nr = 0, rr_drop_b = 0;
  logic prev_qv = 1'b0;
  always @(negedge clk) begin
    if (qv_a) begin
      if (!prev_qv) qpulses++;
      curw++;
      if (curw > maxw) maxw = curw;
      if (!qr_a) qv_nr++;
    end else begin
      curw = 0;
    end
    prev_qv = qv_a;
    if (rv_b && !rr_b) rr_drop_b++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_a_run(input logic [9:0] s, input logic [9:0] e, input int hold);
    @(negedge clk);
    sn_a = s; en_a = e; start_a = 1'b1; qr_a = (hold == 0);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int hold, output int cycles, output logic first_done);
    cycles = 1;
    first_done = done_a;
    while (!done_a && cycles < 3000) begin
      if (cycles == hold + 3) qr_a = 1'b1;
      @(negedge clk);
      cycles++;
    end
    qr_a = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [9:0] s;
    logic [9:0] e;
    int         hold;
    int         exp_cnt;
    int         exp_q;
    int         exp_cyc;   // 0 = latency not checked
  } vec_t;

  vec_t vt[3];

  initial begin
    int         cyc, q0;
    logic       fd;
    string      nm;

    for (int n = 0; n < 8; n++) begin
      nch[n] = 1;
      for (int k = 0; k < 4; k++) adj[n][k] = 10'd0;
    end
    adj[0][0] = 10'd1; adj[0][1] = 10'd2; nch[0] = 2;
    adj[1][0] = 10'd3;                    nch[1] = 1;
    adj[2][0] = 10'd3; adj[2][1] = 10'd1; nch[2] = 2;

    vt[0] = '{"diamond",  10'd0, 10'd3, 0,  3, 4, 0};
    vt[1] = '{"self",     10'd5, 10'd5, 0,  1, 0, 4};
    vt[2] = '{"qr_hold",  10'd0, 10'd3, 10, 3, 4, 0};

    reset = 1'b1; start_a = 1'b0; sn_a = '0; en_a = '0; qr_a = 1'b1;
    start_b = 1'b0; sn_b = '0; en_b = '0; qr_b = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_query_valid", qv_a, 0);
    chk("rst_reply_ready", rr_a, 0);
    chk("rst_busy",        busy_a, 0);
    chk("rst_done",        done_a, 0);
    chk("rst_overflow",    ovf_a, 0);
    chk("rst_path_count",  pc_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven runs on instance A.
    for (int i = 0; i < 3; i++) begin
      q0 = qpulses;
      start_a_run(vt[i].s, vt[i].e, vt[i].hold);
      wait_done_a(vt[i].hold, cyc, fd);
      nm = vt[i].name;
      chk({nm, "_first_done"}, fd, 0);
      chk({nm, "_done"},       done_a, 1);
      chk({nm, "_count"},      pc_a, 64'(vt[i].exp_cnt));
      chk({nm, "_overflow"},   ovf_a, 0);
      chk({nm, "_queries"},    64'(qpulses - q0), 64'(vt[i].exp_q));
      if (vt[i].exp_cyc != 0) chk({nm, "_latency"}, 64'(cyc), 64'(vt[i].exp_cyc));
      repeat (2) @(negedge clk);
    end
    chk("qv_without_ready", 64'(qv_nr), 0);
    chk("qv_pulse_width",   64'(maxw), 1);

    // Overflow on the two-entry stack.
    @(negedge clk);
    sn_b = 10'd0; en_b = 10'd9; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 0; c < 200 && !done_b; c++) @(negedge clk);
    chk("ovf_done",        done_b, 1);
    chk("ovf_flag",        ovf_b, 1);
    chk("ovf_beats",       64'(beats_b), 3);
    chk("ovf_rr_held",     64'(rr_drop_b), 0);

    // Reset during a reply burst, then rerun.
    start_a_run(10'd0, 10'd3, 0);
    for (int c = 0; c < 200 && !rr_a; c++) @(negedge clk);
    chk("t5_in_recv", rr_a, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_query_valid", qv_a, 0);
    chk("t5_reply_ready", rr_a, 0);
    chk("t5_busy",        busy_a, 0);
    chk("t5_done",        done_a, 0);
    chk("t5_overflow",    ovf_a, 0);
    chk("t5_path_count",  pc_a, 0);
    reset = 1'b0;
    @(negedge clk);
    start_a_run(10'd0, 10'd3, 0);
    wait_done_a(0, cyc, fd);
    chk("t5_rerun_done",  done_a, 1);
    chk("t5_rerun_count", pc_a, 3);

    // start while busy is ignored.
    q0 = qpulses;
    start_a_run(10'd0, 10'd3, 0);
    repeat (6) @(negedge clk);
    sn_a = 10'd5; en_a = 10'd5; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(0, cyc, fd);
    chk("t6_busy_start_count",   pc_a, 3);
    chk("t6_busy_start_queries", 64'(qpulses - q0), 4);

    // Restart from DONE with end=1 on a trimmed graph: paths 0->1 and 0->2->1.
    adj[2][0] = 10'd1; nch[2] = 1;
    q0 = qpulses;
    start_a_run(10'd0, 10'd1, 0);
    wait_done_a(0, cyc, fd);
    chk("t6_restart_done_low", fd, 0);
    chk("t6_restart_done",     done_a, 1);
    chk("t6_restart_count",    pc_a, 2);
    chk("t6_restart_queries",  64'(qpulses - q0), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
